// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, frame limits and
// the fill-level width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int UART_MIN_DATA_BITS = 5;

    // A FIFO of N entries must represent levels 0..N inclusive.
    function automatic int uart_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with registered level/full/empty flags; the read
// port shows the head entry combinationally from the storage array.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Power-of-two depth lets the pointers wrap by plain overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal TX FIFO: each popped word is framed with
// start, data, optional parity and stop bits and shifted out on ms_utx.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 9,
    parameter int LVL_W      = uart_lvl_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_enable,
    input  logic [DIV_W-1:0]  cfg_clk_div,
    input  logic [3:0]        cfg_data_bits,
    input  logic              cfg_has_parity,
    input  logic              cfg_odd_parity,
    input  logic              cfg_extend_stop,
    input  logic              cfg_lsb_first,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              uart_tx_busy,
    output logic              uart_tx_empty_it,
    output logic              ms_utx
);
    localparam logic [3:0] MAX_BITS = 4'(DATA_W);
    localparam logic [3:0] MIN_BITS = 4'(UART_MIN_DATA_BITS);

    function automatic logic [3:0] clamp_bits(input logic [3:0] req);
        if (req < MIN_BITS) return MIN_BITS;
        if (req > MAX_BITS) return MAX_BITS;
        return req;
    endfunction

    function automatic logic [DATA_W-1:0] bits_mask(input logic [3:0] n);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(n)) m[i] = 1'b1;
        end
        return m;
    endfunction

    uart_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  div_lim_q, div_lim_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        nbits_q, nbits_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_en_q, par_en_d;
    logic              odd_q, odd_d;
    logic              two_stop_q, two_stop_d;
    logic              lsb_q, lsb_d;
    logic              empty_it_q, empty_it_d;

    logic              push, pop, fifo_full, fifo_empty;
    logic              bit_done, last_data, last_stop;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [3:0]        bit_idx;

    uart_sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(FIFO_DEPTH),
        .LVL_W(LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_ready  = !fifo_full;
    assign push      = wr_valid && wr_ready;
    assign pop       = (state_q == IDLE) && cfg_enable && !fifo_empty;
    assign bit_done  = (div_q == div_lim_q);
    assign last_data = bit_done && (cnt_q == nbits_q - 4'd1);
    assign last_stop = bit_done && (cnt_q == {3'b000, two_stop_q});
    // cnt_q counts transmitted data bits; MSB-first mirrors it around nbits-1.
    assign bit_idx   = lsb_q ? cnt_q : (nbits_q - 4'd1 - cnt_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop)       state_d = START;
            START:   if (bit_done)  state_d = DATA;
            DATA:    if (last_data) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done)  state_d = STOP;
            STOP:    if (last_stop) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        ms_utx = 1'b1;
        unique case (state_q)
            START:   ms_utx = 1'b0;
            DATA:    ms_utx = data_q[bit_idx];
            PARITY:  ms_utx = (^data_q) ^ odd_q;
            default: ms_utx = 1'b1;
        endcase
    end

    always_comb begin
        data_d     = data_q;
        nbits_d    = nbits_q;
        div_lim_d  = div_lim_q;
        par_en_d   = par_en_q;
        odd_d      = odd_q;
        two_stop_d = two_stop_q;
        lsb_d      = lsb_q;
        // Frame settings are frozen at pop so mid-frame cfg edits wait a frame.
        if (pop) begin
            nbits_d    = clamp_bits(cfg_data_bits);
            data_d     = fifo_rd_data & bits_mask(nbits_d);
            div_lim_d  = cfg_clk_div;
            par_en_d   = cfg_has_parity;
            odd_d      = cfg_odd_parity;
            two_stop_d = cfg_extend_stop;
            lsb_d      = cfg_lsb_first;
        end

        if ((state_d != state_q) || (state_q == IDLE)) begin
            div_d = '0;
            cnt_d = '0;
        end else if (bit_done) begin
            div_d = '0;
            cnt_d = cnt_q + 4'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
            cnt_d = cnt_q;
        end

        empty_it_d = (state_q == STOP) && last_stop && (fifo_level == '0) && !push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            cnt_q      <= '0;
            empty_it_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            empty_it_q <= empty_it_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q     <= data_d;
        nbits_q    <= nbits_d;
        div_lim_q  <= div_lim_d;
        par_en_q   <= par_en_d;
        odd_q      <= odd_d;
        two_stop_q <= two_stop_d;
        lsb_q      <= lsb_d;
    end

    assign uart_tx_busy     = (state_q != IDLE);
    assign uart_tx_empty_it = empty_it_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushed words become expected line frames,
// and a line monitor compares every cycle of each frame against them.
module tb_uart_tx_fifo;

    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 9;
    localparam int LVL_W      = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_enable = 1'b0;
    logic [DIV_W-1:0]  cfg_clk_div = '0;
    logic [3:0]        cfg_data_bits = 4'd8;
    logic              cfg_has_parity = 1'b0;
    logic              cfg_odd_parity = 1'b0;
    logic              cfg_extend_stop = 1'b0;
    logic              cfg_lsb_first = 1'b1;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic [LVL_W-1:0]  fifo_level;
    logic              uart_tx_busy;
    logic              uart_tx_empty_it;
    logic              ms_utx;

    uart_tx_fifo #(
        .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_W(DIV_W),
        .LVL_W(LVL_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_enable       (cfg_enable),
        .cfg_clk_div      (cfg_clk_div),
        .cfg_data_bits    (cfg_data_bits),
        .cfg_has_parity   (cfg_has_parity),
        .cfg_odd_parity   (cfg_odd_parity),
        .cfg_extend_stop  (cfg_extend_stop),
        .cfg_lsb_first    (cfg_lsb_first),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .fifo_level       (fifo_level),
        .uart_tx_busy     (uart_tx_busy),
        .uart_tx_empty_it (uart_tx_empty_it),
        .ms_utx           (ms_utx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          nb;
        int          period;
    } frame_t;

    frame_t sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_empty_it = 0;
    int     mdl_lvl = 0;
    bit     mon_en = 1'b0;
    bit     in_frame = 1'b0;
    frame_t cur;
    int     pos = 0;
    int     sub = 0;

    // Reference frame: start 0, clamped data in chosen order, optional parity, 1/2 stops.
    function automatic frame_t make_frame(input logic [8:0] w);
        frame_t f;
        int     n;
        int     k;
        logic   p;
        n = int'(cfg_data_bits);
        if (n < 5) n = 5;
        if (n > DATA_W) n = DATA_W;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        p = cfg_odd_parity;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = cfg_lsb_first ? w[i] : w[n - 1 - i];
            p = p ^ w[i];
        end
        k = 1 + n;
        if (cfg_has_parity) begin
            f.bits[k] = p;
            k = k + 1;
        end
        k = k + (cfg_extend_stop ? 2 : 1);
        f.nb     = k;
        f.period = int'(cfg_clk_div) + 1;
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            in_frame = 1'b0;
        end else begin
            if (uart_tx_empty_it) n_empty_it++;
            if (!in_frame && ms_utx == 1'b0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit seen at %0t, expected none queued", $time);
                end else begin
                    cur      = sb.pop_front();
                    in_frame = 1'b1;
                    pos      = 0;
                    sub      = 0;
                    if (mdl_lvl > 0) mdl_lvl--;
                end
            end
            if (in_frame) begin
                n_checks++;
                if (ms_utx !== cur.bits[pos]) begin
                    n_fail++;
                    $display("FAIL line_bit pos %0d cyc %0d at %0t: got %b expected %b",
                             pos, sub, $time, ms_utx, cur.bits[pos]);
                end
                sub++;
                if (sub == cur.period) begin
                    sub = 0;
                    pos++;
                    if (pos == cur.nb) in_frame = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push1(input logic [8:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        if (mdl_lvl < FIFO_DEPTH) begin
            sb.push_back(make_frame(w));
            mdl_lvl++;
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic measure_busy(output int cyc);
        cyc = 0;
        while (uart_tx_busy && cyc < 4000) begin
            cyc++;
            tick();
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((uart_tx_busy || fifo_level != 0) && c < 5000) begin
            tick();
            c++;
        end
        check({name, "_drain_timeout"}, int'(c < 5000), 1);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic set_cfg(input int div, input int nb, input bit par, input bit odd,
                           input bit ext, input bit lsb);
        cfg_clk_div     = DIV_W'(div);
        cfg_data_bits   = 4'(nb);
        cfg_has_parity  = par;
        cfg_odd_parity  = odd;
        cfg_extend_stop = ext;
        cfg_lsb_first   = lsb;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int idle;
        int ei0;
        int nwords;

        // Reset, with a write attempt that must be dropped.
        rst = 1'b1;
        tick();
        tick();
        wr_valid = 1'b1;
        wr_data  = 9'h1AA;
        tick();
        wr_valid = 1'b0;
        rst      = 1'b0;
        check("rst_ms_utx", ms_utx, 1);
        check("rst_level", fifo_level, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_busy", uart_tx_busy, 0);
        check("rst_empty_it", uart_tx_empty_it, 0);
        tick();
        check("rst_write_dropped", fifo_level, 0);
        mon_en = 1'b1;

        // Basic frame: 0x55, 8N1, LSB first, 4 cycles per bit.
        cfg_enable = 1'b1;
        set_cfg(3, 8, 0, 0, 0, 1);
        ei0 = n_empty_it;
        push1(9'h055);
        check("basic_level_after_push", fifo_level, 1);
        check("basic_line_idle_pop_cycle", ms_utx, 1);
        tick();
        check("basic_start_bit", ms_utx, 0);
        check("basic_busy", uart_tx_busy, 1);
        measure_busy(cyc);
        check("basic_frame_cycles", cyc, 40);
        check("basic_empty_it_pulse", uart_tx_empty_it, 1);
        tick();
        check("basic_empty_it_one_cycle", uart_tx_empty_it, 0);
        check("basic_empty_it_count", n_empty_it - ei0, 1);
        wait_drain("basic");

        // Parity: 7 data bits, 0x07, even then odd.
        set_cfg(2, 7, 1, 0, 0, 1);
        push1(9'h007);
        tick();
        measure_busy(cyc);
        check("even_parity_frame_cycles", cyc, 30);
        wait_drain("even_parity");
        set_cfg(2, 7, 1, 1, 0, 1);
        push1(9'h007);
        tick();
        measure_busy(cyc);
        check("odd_parity_frame_cycles", cyc, 30);
        wait_drain("odd_parity");

        // MSB first, 9 bits, two stop bits.
        set_cfg(1, 9, 0, 0, 1, 0);
        push1(9'h101);
        tick();
        measure_busy(cyc);
        check("msb_frame_cycles", cyc, 24);
        wait_drain("msb");

        // FIFO full with transmitter disabled, then back-to-back drain.
        cfg_enable = 1'b0;
        set_cfg(1, 8, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data  = DATA_W'($urandom_range(0, 511));
            if (mdl_lvl < FIFO_DEPTH) begin
                sb.push_back(make_frame(wr_data));
                mdl_lvl++;
            end
            tick();
            check("full_level", fifo_level, (i + 1 < FIFO_DEPTH) ? i + 1 : FIFO_DEPTH);
            check("full_wr_ready", wr_ready, (i + 1 < FIFO_DEPTH) ? 1 : 0);
        end
        wr_valid = 1'b0;
        check("full_no_tx_when_disabled", uart_tx_busy, 0);
        ei0 = n_empty_it;
        cfg_enable = 1'b1;
        tick();
        check("full_first_frame_started", uart_tx_busy, 1);
        cyc  = 0;
        idle = 0;
        while (cyc < 1000) begin
            tick();
            cyc++;
            if (!uart_tx_busy && fifo_level == 0) break;
            if (!uart_tx_busy) idle++;
        end
        check("full_drain_cycles", cyc, 167);
        check("full_idle_gaps", idle, 7);
        check("full_empty_it_pulse", uart_tx_empty_it, 1);
        tick();
        check("full_empty_it_count", n_empty_it - ei0, 1);
        wait_drain("full");

        // Enable drop during data bit 3 with a second word queued.
        ei0 = n_empty_it;
        push1(9'h0A5);
        push1(9'h03C);
        repeat (8) tick();
        cfg_enable = 1'b0;
        measure_busy(cyc);
        check("endrop_rest_of_frame", cyc, 12);
        repeat (5) tick();
        check("endrop_held_idle", uart_tx_busy, 0);
        check("endrop_line_high", ms_utx, 1);
        check("endrop_level", fifo_level, 1);
        check("endrop_no_empty_it", n_empty_it - ei0, 0);
        cfg_enable = 1'b1;
        tick();
        check("endrop_resume", uart_tx_busy, 1);
        measure_busy(cyc);
        check("endrop_frame2_cycles", cyc, 20);
        tick();
        check("endrop_empty_it_count", n_empty_it - ei0, 1);
        wait_drain("endrop");

        // Reset mid-frame flushes everything without an empty pulse.
        ei0 = n_empty_it;
        push1(9'h0F0);
        push1(9'h00F);
        repeat (5) tick();
        rst = 1'b1;
        sb.delete();
        mdl_lvl = 0;
        tick();
        rst = 1'b0;
        check("midrst_line_high", ms_utx, 1);
        check("midrst_level", fifo_level, 0);
        check("midrst_busy", uart_tx_busy, 0);
        check("midrst_wr_ready", wr_ready, 1);
        repeat (3) tick();
        check("midrst_stays_idle", uart_tx_busy, 0);
        check("midrst_no_empty_it", n_empty_it - ei0, 0);
        push1(9'h0C3);
        wait_drain("midrst_new_frame");

        // Randomised batches, including out-of-range data widths.
        for (int b = 0; b < 8; b++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 15), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
            nwords = $urandom_range(1, 5);
            for (int j = 0; j < nwords; j++) begin
                repeat ($urandom_range(0, 3)) tick();
                push1(9'($urandom_range(0, 511)));
            end
            wait_drain("random");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated synchronous TX FIFO. It is the transmit-side counterpart of the existing receiver.
- Generalised data width: 5..DATA_W bits per frame, selected at run time.
- Selectable parity, stop-bit count and bit order.
- Own baud divider, so it runs standalone from the receiver's clock generator.
- Sits between the register/high-level interface and the ms_utx pad.

Parameters:
DATA_W, 9, maximum data bits per frame (5..9)
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2
DIV_W, 9, width of baud divider configuration
LVL_W, clog2(FIFO_DEPTH+1), derived width of fill level

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cfg_enable  in  1  allow new frames to start
cfg_clk_div  in  DIV_W  bit period = cfg_clk_div+1 clk cycles
cfg_data_bits  in  4  data bits per frame; clamped to 5..DATA_W
cfg_has_parity  in  1  append parity bit
cfg_odd_parity  in  1  1 = odd parity, 0 = even parity
cfg_extend_stop  in  1  1 = two stop bits, 0 = one stop bit
cfg_lsb_first  in  1  1 = LSB first, 0 = MSB first
wr_valid  in  1  push request
wr_data  in  DATA_W  word to push; bits at or above cfg_data_bits ignored
wr_ready  out  1  FIFO can accept; registered, equals (level < FIFO_DEPTH)
fifo_level  out  LVL_W  registered entry count
uart_tx_busy  out  1  FSM not IDLE
uart_tx_empty_it  out  1  one-cycle pulse: frame finished and FIFO empty
ms_utx  out  1  serial line, idle high

Behaviour:
- Reset (rst=1 at a clk edge) and next-cycle values: ms_utx=1, fifo_level=0, wr_ready=1, uart_tx_busy=0, uart_tx_empty_it=0, FSM=IDLE, divider=0. Writes during reset are dropped.
- Reset mid-frame aborts the frame immediately; no empty_it pulse.
- FIFO push: wr_valid && wr_ready.
- FIFO pop: only in IDLE, with cfg_enable=1 and registered level>0.
  - Push and pop in the same cycle: level unchanged.
  - Push into an empty FIFO: pop occurs the next cycle; no bypass path.
- Frame latch at pop: popped word and all cfg_* values are captured into frame registers. Configuration changes mid-frame take effect on the next frame only.
- Latency: push at edge N (IDLE, empty FIFO) -> level=1 after N -> pop at N+1 -> ms_utx=0 (start bit) from N+2.
- Divider counts 0..cfg_clk_div and restarts on every state entry. Each bit is driven for exactly cfg_clk_div+1 cycles. cfg_clk_div=0 gives one cycle per bit.
- FSM:
  - IDLE: ms_utx=1; on pop -> START.
  - START: ms_utx=0, one bit period -> DATA.
  - DATA: bit index counter. LSB-first sends bit 0 upward; MSB-first sends bit (nbits-1) downward. After nbits periods -> PARITY if has_parity, else STOP.
  - PARITY: bit = XOR of the nbits transmitted bits, inverted if odd parity. One period -> STOP.
  - STOP: ms_utx=1 for 1 or 2 periods -> IDLE.
- Frame end: on the last STOP cycle, if level==0 and no push in that cycle, pulse uart_tx_empty_it.
- Back-to-back frames: IDLE lasts exactly one cycle (the pop cycle) when the FIFO is non-empty.
- Clamp: cfg_data_bits <5 uses 5; >DATA_W uses DATA_W.
- cfg_enable=0 mid-frame: the current frame completes, then the FSM holds IDLE. FIFO pushes are still accepted.
- Full FIFO: wr_ready=0; a write attempt is ignored and data is not overwritten. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - UART_MIN_DATA_BITS=5
  - helper constant for LVL_W computation
- One sub-module: uart_sync_fifo, a generic synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/data/level/full/empty.
  - Synchronous active-high reset.
- FSM, divider and parity logic stay in uart_tx_fifo.

Test Plan:
- Basic frame. cfg_clk_div=3, 8 bits, no parity, LSB-first, 1 stop; push 0x55 -> ms_utx = 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles (40 cycles). Start bit begins 2 cycles after push. uart_tx_empty_it pulses once at the end.
- Parity. 7 bits, push 0x07. Even parity -> parity bit 1; odd parity -> 0. Frame is 10 bit periods.
- MSB-first, 9 bits, 2 stops. Push 0x101 -> data 1,0,0,0,0,0,0,0,1 then two high stop bits; 12 bit periods total.
- FIFO full. cfg_enable=0, FIFO_DEPTH=8, 9 back-to-back pushes -> wr_ready drops after the 8th; level=8; 9th word absent from output. Enable -> 8 frames back-to-back, one IDLE cycle between frames, single empty_it pulse after the last.
- Enable drop. Deassert cfg_enable during data bit 3 of frame 1 with 2 words queued -> frame 1 completes intact, ms_utx stays 1, level=1. Re-enable -> frame 2 sent.
- Reset mid-frame. rst=1 for one cycle during a DATA bit -> next cycle ms_utx=1, level=0, busy=0, no empty_it. A new push transmits normally.
